// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy count, full/empty and programmable
// almost-full/almost-empty flags, a registered read port, and sticky
// overflow/underflow error flags that software can clear.
module sync_fifo_flags #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic                     full_o,
    output logic                     almost_full_o,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     rd_valid_o,
    output logic                     empty_o,
    output logic                     almost_empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     underflow_o,
    input  logic                     clr_err_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    // Storage is deliberately not reset; only pointers and count define validity.
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [DATA_W-1:0] data_r;
    logic              rd_valid_r;
    logic              overflow_r;
    logic              underflow_r;

    logic              full_s;
    logic              almost_full_s;
    logic              empty_s;
    logic              almost_empty_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic [CW-1:0]     count_nxt_s;
    logic              overflow_nxt_s;
    logic              underflow_nxt_s;

    // Status flags decode the registered count; acceptance uses this cycle's flags,
    // so a same-cycle read never frees space for a write and vice versa.
    always_comb begin
        full_s         = (count_r == DEPTH_C);
        almost_full_s  = (count_r >= AF_C);
        empty_s        = (count_r == {CW{1'b0}});
        almost_empty_s = (count_r <= AE_C);
        wr_acc_s       = wr_en_i && !full_s;
        rd_acc_s       = rd_en_i && !empty_s;
    end

    // Occupancy update: balanced or idle cycles leave the count alone.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Sticky error flags: a new error wins over a same-cycle clear.
    always_comb begin
        overflow_nxt_s  = overflow_r;
        underflow_nxt_s = underflow_r;
        if (wr_en_i && full_s) begin
            overflow_nxt_s = 1'b1;
        end else if (clr_err_i) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end
        if (rd_en_i && empty_s) begin
            underflow_nxt_s = 1'b1;
        end else if (clr_err_i) begin
            underflow_nxt_s = 1'b0;
        end else begin
            underflow_nxt_s = underflow_r;
        end
    end

    // Write port into storage; reset suppresses a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Pointers, count, registered read data and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            data_r      <= {DATA_W{1'b0}};
            rd_valid_r  <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                data_r   <= mem_r[rd_ptr_r];
            end
            rd_valid_r  <= rd_acc_s;
            count_r     <= count_nxt_s;
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
        end
    end

    assign full_o         = full_s;
    assign almost_full_o  = almost_full_s;
    assign empty_o        = empty_s;
    assign almost_empty_o = almost_empty_s;
    assign count_o        = count_r;
    assign data_o         = data_r;
    assign rd_valid_o     = rd_valid_r;
    assign overflow_o     = overflow_r;
    assign underflow_o    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags (DATA_W=8, DEPTH=16, AF=14, AE=2).
// Read data is checked by a scoreboard: every read the bench expects to be
// accepted pushes its hand-computed word; a monitor pops on rd_valid_o.
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst;
    logic       wr_en_i;
    logic [7:0] data_i;
    logic       full_o;
    logic       almost_full_o;
    logic       rd_en_i;
    logic [7:0] data_o;
    logic       rd_valid_o;
    logic       empty_o;
    logic       almost_empty_o;
    logic [4:0] count_o;
    logic       overflow_o;
    logic       underflow_o;
    logic       clr_err_i;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_q[$];

    sync_fifo_flags #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en_i       (wr_en_i),
        .data_i        (data_i),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .rd_en_i       (rd_en_i),
        .data_o        (data_o),
        .rd_valid_o    (rd_valid_o),
        .empty_o       (empty_o),
        .almost_empty_o(almost_empty_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o),
        .clr_err_i     (clr_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
        wr_en_i   = wr;
        data_i    = d;
        rd_en_i   = rd;
        clr_err_i = clr;
        @(posedge clk);
        #1;
        wr_en_i   = 1'b0;
        rd_en_i   = 1'b0;
        clr_err_i = 1'b0;
    endtask

    // Monitor: every presented read word must match the oldest expectation.
    always @(negedge clk) begin
        if (rd_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_rd_valid: got data 0x%0h expected no read", data_o);
            end else begin
                chk("rd_data", int'(data_o), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; wr_en_i = 1'b0; data_i = 8'h00; rd_en_i = 1'b0; clr_err_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_count", int'(count_o), 0);
        chk("rst_empty", int'(empty_o), 1);
        chk("rst_aempty", int'(almost_empty_o), 1);
        chk("rst_full", int'(full_o), 0);
        chk("rst_afull", int'(almost_full_o), 0);
        chk("rst_valid", int'(rd_valid_o), 0);
        chk("rst_ovf", int'(overflow_o), 0);
        chk("rst_unf", int'(underflow_o), 0);
        chk("rst_data", int'(data_o), 0);

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            chk("fill_count", int'(count_o), i);
            chk("fill_afull", int'(almost_full_o), (i >= 14) ? 1 : 0);
            chk("fill_full", int'(full_o), (i == 16) ? 1 : 0);
            chk("fill_aempty", int'(almost_empty_o), (i <= 2) ? 1 : 0);
        end

        // Write while full
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_flag", int'(overflow_o), 1);
        chk("ovf_count", int'(count_o), 16);
        chk("ovf_full", int'(full_o), 1);

        // Drain: 0x01..0x10, no 0xAA
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i + 1));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_valid", int'(rd_valid_o), 1);
            chk("drain_count", int'(count_o), 15 - i);
            chk("drain_empty", int'(empty_o), (i == 15) ? 1 : 0);
            chk("drain_aempty", int'(almost_empty_o), ((15 - i) <= 2) ? 1 : 0);
        end

        // Extra read at empty
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_flag", int'(underflow_o), 1);
        chk("unf_valid", int'(rd_valid_o), 0);
        chk("unf_data_hold", int'(data_o), 16);
        chk("unf_count", int'(count_o), 0);
        chk("unf_ovf_sticky", int'(overflow_o), 1);

        // Clear errors
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", int'(overflow_o), 0);
        chk("clr_unf", int'(underflow_o), 0);

        // Clear with same-cycle underflow: error wins
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("clr_prio_unf", int'(underflow_o), 1);
        chk("clr_prio_ovf", int'(overflow_o), 0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr2_unf", int'(underflow_o), 0);

        // Simultaneous read/write at empty
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        chk("rw_empty_count", int'(count_o), 1);
        chk("rw_empty_valid", int'(rd_valid_o), 0);
        chk("rw_empty_unf", int'(underflow_o), 1);
        exp_q.push_back(8'h55);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        chk("rw_empty_drain", int'(count_o), 0);
        chk("rw_empty_clr", int'(underflow_o), 0);

        // Count 5 then 40 balanced cycles across pointer wrap (values 0x20+k)
        for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
        chk("stream_pre_count", int'(count_o), 5);
        for (int j = 0; j < 40; j++) begin
            exp_q.push_back(8'(8'h20 + j));
            cyc(1'b1, 8'(8'h20 + j + 5), 1'b1, 1'b0);
            chk("stream_count", int'(count_o), 5);
        end
        for (int j = 40; j < 45; j++) begin
            exp_q.push_back(8'(8'h20 + j));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("stream_post_count", int'(count_o), 0);

        // Simultaneous read/write at full (values 0x80..0x8F)
        for (int k = 0; k < 16; k++) cyc(1'b1, 8'(8'h80 + k), 1'b0, 1'b0);
        chk("rw_full_pre", int'(full_o), 1);
        exp_q.push_back(8'h80);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("rw_full_count", int'(count_o), 15);
        chk("rw_full_ovf", int'(overflow_o), 1);
        chk("rw_full_full", int'(full_o), 0);
        for (int k = 1; k < 16; k++) begin
            exp_q.push_back(8'(8'h80 + k));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("rw_full_drained", int'(empty_o), 1);

        // Reset mid-stream at count 9 with sticky flags set and a read/write pending
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_unf", int'(underflow_o), 1);
        for (int k = 0; k < 9; k++) cyc(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
        chk("pre_rst_count", int'(count_o), 9);
        rst = 1'b1;
        cyc(1'b1, 8'h77, 1'b1, 1'b1);
        rst = 1'b0;
        chk("mid_rst_count", int'(count_o), 0);
        chk("mid_rst_empty", int'(empty_o), 1);
        chk("mid_rst_ovf", int'(overflow_o), 0);
        chk("mid_rst_unf", int'(underflow_o), 0);
        chk("mid_rst_valid", int'(rd_valid_o), 0);
        chk("mid_rst_data", int'(data_o), 0);

        // Fresh traffic after reset
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        exp_q.push_back(8'h99);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_count", int'(count_o), 0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
